// File: rtl/operand_sequencer.sv
// operand_sequencer: walks a fixed 4-vector x 4-opcode sweep through a shared
// multi-cycle execution unit using a start/done handshake, capturing and
// holding each result before advancing.
// Optional macro LOOP_EN: when defined the sweep repeats forever instead of
// stopping in DONE after one pass.
module operand_sequencer #(
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  input  logic              unit_done,
  input  logic [DATA_W-1:0] unit_result,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic [1:0]        opcode,
  output logic              start,
  output logic [DATA_W-1:0] result_out,
  output logic              result_valid,
  output logic [1:0]        vec_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_vec;
  logic [1:0]        w_next_vec;
  logic [1:0]        r_opc;
  logic [1:0]        w_next_opc;
  logic [HW-1:0]     r_hold_cnt;
  logic [HW-1:0]     w_next_hold;
  logic [TW-1:0]     r_to_cnt;
  logic [TW-1:0]     w_next_to;
  logic              w_capture;
  logic              w_timeout;
  logic [DATA_W-1:0] r_operand;
  logic [DATA_W-1:0] r_result;
  logic              r_result_valid;
  logic              r_start;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  // Operand pattern for a vector index: one nibble replicated across DATA_W.
  function automatic logic [DATA_W-1:0] f_pattern(input logic [1:0] idx);
    logic [3:0]        nib;
    logic [DATA_W-1:0] pat;
    case (idx)
      2'd0:    nib = 4'h0;
      2'd1:    nib = 4'h4;
      2'd2:    nib = 4'h7;
      default: nib = 4'hF;
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      pat[i] = nib[i[1:0]];
    end
    return pat;
  endfunction

  // Next-state, counter and index-advance logic.
  always_comb begin
    w_next_state = r_state;
    w_next_vec   = r_vec;
    w_next_opc   = r_opc;
    w_next_hold  = r_hold_cnt;
    w_next_to    = r_to_cnt;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_hold = '0;
        w_next_to   = '0;
        if (run) begin
          w_next_state = S_ISSUE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        // A done pulse during ISSUE belongs to nothing we launched; ignore it.
        w_next_to    = '0;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (unit_done) begin
          w_capture    = 1'b1;
          w_next_hold  = '0;
          w_next_state = S_HOLD;
        end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_next_hold  = '0;
          w_next_state = S_HOLD;
        end else begin
          w_next_to = r_to_cnt + TW'(1);
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          w_next_hold = '0;
          if ((r_vec == 2'd3) && (r_opc == 2'd3)) begin
`ifdef LOOP_EN
            w_next_vec   = 2'd0;
            w_next_opc   = 2'd0;
            w_next_state = run ? S_ISSUE : S_IDLE;
`else
            w_next_state = S_DONE;
`endif
          end else begin
            w_next_opc = r_opc + 2'd1;
            if (r_opc == 2'd3) begin
              w_next_vec = r_vec + 2'd1;
            end else begin
              w_next_vec = r_vec;
            end
            w_next_state = run ? S_ISSUE : S_IDLE;
          end
        end else begin
          w_next_hold = r_hold_cnt + HW'(1);
        end
      end
      S_DONE: begin
        if (!run) begin
          w_next_vec   = 2'd0;
          w_next_opc   = 2'd0;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, counters, indices and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state        <= S_IDLE;
      r_vec          <= 2'd0;
      r_opc          <= 2'd0;
      r_hold_cnt     <= '0;
      r_to_cnt       <= '0;
      r_operand      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_start        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_vec          <= w_next_vec;
      r_opc          <= w_next_opc;
      r_hold_cnt     <= w_next_hold;
      r_to_cnt       <= w_next_to;
      r_operand      <= f_pattern(w_next_vec);
      r_result       <= w_capture ? unit_result : r_result;
      r_result_valid <= w_capture;
      r_start        <= (w_next_state == S_ISSUE);
      r_busy         <= (w_next_state == S_ISSUE) || (w_next_state == S_WAIT) ||
                        (w_next_state == S_HOLD);
      r_done         <= (w_next_state == S_DONE);
      r_error        <= r_error | w_timeout;
    end
  end

  assign opA          = r_operand;
  assign opB          = r_operand;
  assign opcode       = r_opc;
  assign vec_idx      = r_vec;
  assign start        = r_start;
  assign result_out   = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: the driver pushes expected launches
// and results; a monitor pops and compares on start / result_valid.
module tb_operand_sequencer;

  localparam int DATA_W      = 32;
  localparam int HOLD_CYCLES = 4;
  localparam int TIMEOUT     = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              run = 1'b0;
  logic              unit_done = 1'b0;
  logic [DATA_W-1:0] unit_result = '0;
  logic [DATA_W-1:0] opA, opB, result_out;
  logic [1:0]        opcode, vec_idx;
  logic              start, result_valid, busy, done, error;

  operand_sequencer #(.DATA_W(DATA_W), .HOLD_CYCLES(HOLD_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .run(run), .unit_done(unit_done), .unit_result(unit_result),
    .opA(opA), .opB(opB), .opcode(opcode), .start(start), .result_out(result_out),
    .result_valid(result_valid), .vec_idx(vec_idx), .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [1:0] v; logic [1:0] o; } op_t;
  op_t               q_op[$];
  logic [DATA_W-1:0] q_res[$];

  // Hand-written operand and sum tables per vector index.
  logic [DATA_W-1:0] pat_tab [4] = '{32'h00000000, 32'h44444444, 32'h77777777, 32'hFFFFFFFF};
  logic [DATA_W-1:0] sum_tab [4] = '{32'h00000000, 32'h88888888, 32'hEEEEEEEE, 32'hFFFFFFFE};

  int n_checks = 0;
  int n_fail   = 0;
  int unit_delay = 3;
  bit unit_mute  = 1'b0;
  bit seen_done  = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input int sel, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge CLK);
      case (sel)
        0:       hit = start;
        1:       hit = result_valid;
        2:       hit = !busy;
        3:       hit = done;
        4:       hit = start && (vec_idx == 2'd1) && (opcode == 2'd2);
        5:       hit = start && (vec_idx == 2'd0) && (opcode == 2'd0);
        default: hit = 1'b1;
      endcase
    end
    check(name, {127'd0, hit}, 128'd1);
  endtask

  task automatic push_op(input logic [1:0] v, input logic [1:0] o, input bit with_res);
    op_t e;
    e.v = v;
    e.o = o;
    q_op.push_back(e);
    if (with_res) q_res.push_back(sum_tab[v]);
  endtask

  // Execution unit model: returns opA+opB unit_delay cycles after start.
  initial begin
    logic [DATA_W-1:0] acc;
    forever begin
      @(negedge CLK);
      if (start && !unit_mute && !RST) begin
        acc = opA + opB;
        repeat (unit_delay - 1) @(negedge CLK);
        unit_done   = 1'b1;
        unit_result = acc;
        @(negedge CLK);
        unit_done   = 1'b0;
      end
    end
  end

  // Monitor: compare every launch and every captured result against the queues.
  always @(negedge CLK) begin
    if (done) seen_done = 1'b1;
    if (!RST && start) begin
      if (q_op.size() == 0) begin
        check("unexpected_start", 128'd1, 128'd0);
      end else begin
        op_t e;
        e = q_op.pop_front();
        check("launch_ops", {vec_idx, opcode, opA, opB}, {e.v, e.o, pat_tab[e.v], pat_tab[e.v]});
      end
    end
    if (!RST && result_valid) begin
      if (q_res.size() == 0) begin
        check("unexpected_result_valid", 128'd1, 128'd0);
      end else begin
        logic [DATA_W-1:0] r;
        r = q_res.pop_front();
        check("result_out", result_out, r);
      end
    end
  end

  initial begin
    // Reset state.
    #1 RST = 1'b1;
    #2;
    check("reset_outputs", {opA, opB, result_out, opcode, vec_idx, start, result_valid, busy, done, error}, 128'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Reset mid-WAIT; the late done pulse must be ignored.
    unit_delay = 6;
    push_op(2'd0, 2'd0, 1'b0);
    run = 1'b1;
    wait_for(0, 5, "a_start");
    run = 1'b0;
    @(negedge CLK);
    check("a_busy_in_wait", {127'd0, busy}, 128'd1);
    #2 RST = 1'b1;
    #1;
    check("a_reset_immediate", {opA, opB, result_out, opcode, vec_idx, start, result_valid, busy, done, error}, 128'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    check("a_idle_after_stray", {127'd0, busy}, 128'd0);
    unit_delay = 3;

    // Full pass with a pause at vec1/opcode2.
    for (int v = 0; v < 4; v++)
      for (int o = 0; o < 4; o++)
        push_op(v[1:0], o[1:0], 1'b1);
`ifdef LOOP_EN
    push_op(2'd0, 2'd0, 1'b1);
`endif
    run = 1'b1;
    check("b_start_before_edge", {127'd0, start}, 128'd0);
    @(negedge CLK);
    check("b_start_latency", {127'd0, start}, 128'd1);
    wait_for(1, 20, "b_first_result");
    repeat (HOLD_CYCLES - 1) @(negedge CLK);
    check("b_no_early_start", {127'd0, start}, 128'd0);
    @(negedge CLK);
    check("b_second_start", {125'd0, start, opcode}, {125'd0, 1'b1, 2'd1});
    wait_for(4, 200, "b_reach_v1o2");
    run = 1'b0;
    wait_for(2, 60, "b_pause_idle");
    check("b_pause_idx", {vec_idx, opcode, opA}, {2'd1, 2'd3, 32'h44444444});
    run = 1'b1;
    @(negedge CLK);
    check("b_resume_start", {127'd0, start}, 128'd1);
`ifdef LOOP_EN
    wait_for(5, 400, "b_loop_restart");
    run = 1'b0;
    wait_for(2, 60, "b_loop_idle");
    check("b_loop_idx", {vec_idx, opcode}, {2'd0, 2'd1});
`else
    wait_for(3, 400, "b_pass_done");
    check("b_done_state", {busy, done, vec_idx, opcode, result_out}, {1'b0, 1'b1, 2'd3, 2'd3, 32'hFFFFFFFE});
    run = 1'b0;
    @(negedge CLK);
    check("b_done_to_idle", {done, busy, vec_idx, opcode}, {1'b0, 1'b0, 2'd0, 2'd0});
`endif
    check("b_results_drained", q_res.size(), 128'd0);

    // Timeout: unit never answers.
    unit_mute = 1'b1;
`ifdef LOOP_EN
    push_op(2'd0, 2'd1, 1'b0);
`else
    push_op(2'd0, 2'd0, 1'b0);
`endif
    run = 1'b1;
    wait_for(0, 5, "c_start");
    repeat (TIMEOUT) @(negedge CLK);
    check("c_error_not_early", {127'd0, error}, 128'd0);
    @(negedge CLK);
`ifdef LOOP_EN
    check("c_timeout_state", {error, busy, result_out}, {1'b1, 1'b1, 32'h00000000});
`else
    check("c_timeout_state", {error, busy, result_out}, {1'b1, 1'b1, 32'hFFFFFFFE});
`endif
    unit_mute = 1'b0;
`ifdef LOOP_EN
    push_op(2'd0, 2'd2, 1'b1);
`else
    push_op(2'd0, 2'd1, 1'b1);
`endif
    wait_for(0, 20, "c_next_start");
    run = 1'b0;
    wait_for(2, 60, "c_idle");
    check("c_error_sticky", {127'd0, error}, 128'd1);
    #2 RST = 1'b1;
    #1;
    check("c_error_cleared", {error, result_out}, 128'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

`ifdef LOOP_EN
    check("done_never_seen", {127'd0, seen_done}, 128'd0);
`endif
    check("queues_empty", q_op.size() + q_res.size(), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Controller that walks a fixed operand/opcode test sweep through a shared multi-cycle execution unit.
- Presents opA/opB/opcode and pulses start, then waits on the unit's done handshake. Captures each result, holds it for display, then advances.
- Sits between the board-level run switch and the arithmetic unit under test. Replaces free-running operand cycling with handshake-driven sequencing.

Parameters:
- DATA_W, 32, operand/result width
- HOLD_CYCLES, 4, cycles each captured result is held before advancing (>=1)
- TIMEOUT, 16, max WAIT cycles before declaring unit hang (>=2)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = sequence, 0 = pause at next vector boundary
- unit_done  in  1  single-cycle pulse from execution unit, result valid
- unit_result  in  DATA_W  execution unit result, sampled when unit_done=1
- opA  out  DATA_W  operand A to unit
- opB  out  DATA_W  operand B to unit
- opcode  out  2  operation select to unit
- start  out  1  one-cycle pulse launching the unit
- result_out  out  DATA_W  last captured result
- result_valid  out  1  one-cycle pulse on capture
- vec_idx  out  2  current operand vector index
- busy  out  1  high in ISSUE/WAIT/HOLD
- done  out  1  high in DONE state
- error  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): state IDLE; opA=opB=result_out=0; opcode=0; vec_idx=0; start=result_valid=busy=done=error=0; hold/timeout counters 0.
- Operand table, opA=opB: idx0 0x00000000, idx1 0x44444444, idx2 0x77777777, idx3 0xFFFFFFFF. For DATA_W != 32, the pattern nibble is replicated across the width.
- Sweep order: opcode is the inner loop 0..3, vec_idx is the outer loop 0..3; 16 operations per pass.
- IDLE: opA/opB/opcode are driven from the current indices. run=1 sampled -> ISSUE on the next edge.
- ISSUE: start=1 for exactly one cycle -> WAIT. A unit_done arriving in the ISSUE cycle is ignored.
- WAIT: timeout counter increments each cycle.
  - unit_done=1 -> result_out<=unit_result; result_valid pulses the following cycle; -> HOLD.
  - Counter reaches TIMEOUT without unit_done -> error<=1 (sticky until RST); result_out unchanged; no result_valid; -> HOLD.
- HOLD: count HOLD_CYCLES cycles. On the last cycle, advance the indices:
  - opcode+1.
  - On opcode wrap 3->0, vec_idx+1.
  - If vec_idx=3 and opcode=3 (pass complete) -> DONE.
  - Else run=1 -> ISSUE; run=0 -> IDLE with advanced indices retained (pause/resume).
- DONE: done=1; operands frozen at last vector. run=0 -> IDLE with indices reset to 0.
- opA/opB/opcode update only on index advance; they are stable from ISSUE through HOLD.
- Latency: run high at edge N -> start high at N+1. unit_done at edge M -> result_valid at M+1 and HOLD entered at M+1.
- run is ignored outside IDLE, HOLD-end and DONE. Dropping run mid-operation never aborts a launched operation.
- RST mid-operation: immediate return to reset values. A later stray unit_done is ignored because the block is in IDLE.

Optional Feature:
- LOOP_EN defined: on pass completion, indices wrap to 0 and the FSM goes to ISSUE if run=1 (IDLE if run=0). DONE is never entered and done stays 0.
- LOOP_EN undefined: single pass ending in DONE, as described above.

Test Plan:
- Reset check: RST=1 mid-WAIT -> all outputs 0 immediately, state IDLE; unit_done pulsed afterwards -> no result_valid.
- Basic op: run=1, unit model returns opA+opB after 3 cycles -> start one cycle after run, result_out=0x00000000, result_valid one pulse. Second op (opcode 1, idx0) starts HOLD_CYCLES cycles later.
- Full pass (LOOP_EN undefined): 16 ops complete in order; the idx3 result is captured as 0xFFFFFFFE; done=1, busy=0. run=0 -> IDLE, vec_idx=0.
- Pause: drop run during the vec1/opcode2 WAIT -> that operation completes and the FSM idles with vec_idx=1, opcode=3. Reassert run -> resumes there with opA=0x44444444.
- Timeout: unit never responds -> error=1 after TIMEOUT WAIT cycles, no result_valid, sequence advances. error stays 1 through later good ops until RST.
- LOOP_EN defined: after op 16, vec_idx wraps to 0 and start pulses again; done never asserts.
